// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared fetch-stage state encoding, NOP word and instruction field positions
package pipeline_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, BUF} fetch_state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam logic [31:0] PC_INC_DEF = 32'd4;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int RD_MSB = 15;
  localparam int RD_LSB = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: pipeline register with flush > stall > load priority; a non-valid load is a bubble
module if_id_reg
  import pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        stall,
  input  logic        ld_valid,
  input  logic [31:0] ld_instr,
  input  logic [31:0] ld_pc,
  input  logic [31:0] ld_pc4,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc4
);
  // bubbles clear valid/instr but keep pc/pc4 from the last real instruction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
      pc    <= '0;
      pc4   <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end else if (!stall) begin
      valid <= ld_valid;
      instr <= ld_valid ? ld_instr : NOP_INSTR;
      if (ld_valid) begin
        pc  <= ld_pc;
        pc4 <= ld_pc4;
      end
    end
  end
endmodule

// File: rtl/estagio_busca.sv
// estagio_busca: instruction fetch stage with PC, one-entry skid buffer, branch redirect and IF/ID register
module estagio_busca
  import pipeline_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = PC_INC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [4:0]  if_id_rs,
  output logic [4:0]  if_id_rt,
  output logic [4:0]  if_id_rd,
  output logic [15:0] if_id_imm
);
  fetch_state_t state, state_nxt;
  logic [31:0] pc, pc_nxt, skid_instr, skid_pc, ld_instr, ld_pc;
  logic accept, ld_valid, unused_target_bits;
  assign unused_target_bits = ^branch_target[1:0];
  // next state, next pc and the word offered to IF/ID; a branch discards whatever was fetched or buffered
  always_comb begin
    imem_req  = state == FETCH;
    accept    = imem_req & imem_ready;
    ld_valid  = !branch_taken && (state == FETCH ? accept : state == BUF);
    ld_instr  = state == BUF ? skid_instr : imem_rdata;
    ld_pc     = state == BUF ? skid_pc : pc;
    state_nxt = branch_taken ? FETCH :
                state == IDLE ? FETCH :
                state == FETCH ? ((accept && stall) ? BUF : FETCH) :
                (stall ? BUF : FETCH);
    pc_nxt    = branch_taken ? {branch_target[31:2], 2'b00} :
                (ld_valid && !stall) ? pc + PC_INC : pc;
  end
  // state, pc and skid buffer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pc         <= PC_RESET;
      skid_instr <= NOP_INSTR;
      skid_pc    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (accept && stall && !branch_taken) begin
        skid_instr <= imem_rdata;
        skid_pc    <= pc;
      end
    end
  end
  assign imem_addr = pc;
  if_id_reg u_if_id (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .stall    (stall),
    .ld_valid (ld_valid),
    .ld_instr (ld_instr),
    .ld_pc    (ld_pc),
    .ld_pc4   (ld_pc + PC_INC),
    .valid    (if_id_valid),
    .instr    (if_id_instr),
    .pc       (if_id_pc),
    .pc4      (if_id_pc4)
  );
  assign if_id_rs  = if_id_instr[RS_MSB:RS_LSB];
  assign if_id_rt  = if_id_instr[RT_MSB:RT_LSB];
  assign if_id_rd  = if_id_instr[RD_MSB:RD_LSB];
  assign if_id_imm = if_id_instr[IMM_MSB:IMM_LSB];
endmodule

// File: doc/estagio_busca.md
Name: estagio_busca

Overview:
- Instruction-fetch stage of the pipelined MIPS core, directly upstream of the decode/register-file/ALU datapath.
- Owns the PC and drives a request/ready instruction-memory interface.
- Absorbs stalls with a one-entry skid buffer and redirects on taken branches.
- Registers the IF/ID pipeline register, including the pre-split rs/rt/rd/immediate fields that the register file and sign extender consume.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset (word aligned).
- PC_INC, 4, PC increment per sequential fetch.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  hold IF/ID and PC (hazard unit).
- flush  in  1  force a bubble into IF/ID.
- branch_taken  in  1  redirect fetch to branch_target.
- branch_target  in  32  redirect address; bits [1:0] ignored, treated as 00.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address (current PC).
- imem_ready  in  1  memory returns imem_rdata this cycle (valid only when imem_req=1).
- imem_rdata  in  32  fetched instruction.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_instr  out  32  instruction word (32'h0 = NOP when bubble).
- if_id_pc  out  32  address of if_id_instr.
- if_id_pc4  out  32  if_id_pc + PC_INC.
- if_id_rs  out  5  if_id_instr[25:21].
- if_id_rt  out  5  if_id_instr[20:16].
- if_id_rd  out  5  if_id_instr[15:11].
- if_id_imm  out  16  if_id_instr[15:0].

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=PC_RESET, state=IDLE, skid buffer empty.
  - if_id_valid=0, if_id_instr/pc/pc4=0, derived fields therefore 0.
  - imem_req=0.
- FSM states: IDLE, FETCH, BUF.
  - IDLE: imem_req=0 for exactly one cycle after reset release, then FETCH.
  - FETCH: imem_req=1, imem_addr=pc. Accept = imem_req & imem_ready.
    - Accept & !stall & !branch_taken: IF/ID <= {1, imem_rdata, pc, pc+PC_INC}; pc <= pc+PC_INC; stay FETCH.
    - Accept & stall & !branch_taken: skid <= {imem_rdata, pc}; pc unchanged; go to BUF.
    - No accept & !stall: IF/ID <= bubble (valid=0, instr=0, pc/pc4 keep their previous values).
  - BUF: imem_req=0; IF/ID held while stall=1.
    - When stall=0: IF/ID <= {1, skid instr, skid pc, skid pc+PC_INC}; pc <= pc+PC_INC; go to FETCH.
- IF/ID update priority: flush > stall > load.
  - flush=1: valid=0, instr=0 next edge, regardless of stall.
  - stall=1 (no flush): IF/ID holds.
- branch_taken priority: highest for pc.
  - pc <= {branch_target[31:2],2'b00}.
  - Any instruction accepted that cycle is discarded and never enters IF/ID.
  - A full skid buffer is emptied.
  - Next state FETCH, even when stall=1.
  - IF/ID follows the flush/stall rules; with neither asserted it loads a bubble.
  - No delay slot.
- Simultaneous stall and branch_taken: pc redirects, IF/ID holds.
- Wrap-around: pc=32'hFFFF_FFFC, +PC_INC gives 32'h0000_0000 (modulo 2^32); if_id_pc4 wraps identically.
- Latency:
  - Instruction accepted in cycle N appears on if_id_* in cycle N+1 when unstalled.
  - First request occurs in cycle 1 after reset release.
- Field outputs are combinational slices of the if_id_instr register; no extra latency.
- Reset asserted mid-fetch or mid-BUF aborts everything: buffer contents lost, outputs return to reset values asynchronously.

Decomposition:
- Shared package (pipeline_pkg):
  - state encoding (IDLE/FETCH/BUF)
  - NOP_INSTR=32'h0
  - field bit-range constants (RS_MSB/LSB, RT_, RD_, IMM_)
  - PC_INC default
- Sub-module: if_id_reg.
  - Holds valid/instr/pc/pc4 with flush>stall>load priority and reset.
  - Reused later for ID/EX-style registers.
- FSM, PC and skid buffer stay in estagio_busca.

Test Plan:
- Reset release, imem_ready tied 1 -> cycle 0 imem_req=0; cycle 1 imem_addr=0; cycle 2 if_id_pc=0, valid=1, if_id_rs/rt/rd/imm match imem_rdata=32'h012A4020 (rs=9, rt=10, rd=8, imm=16'h4020).
- imem_ready low 3 cycles at pc=8 -> imem_addr held at 8, three bubbles (valid=0, instr=0), then instr at pc=8 with if_id_pc4=12.
- stall=1 on the accepting cycle at pc=16 for 2 cycles -> BUF entered, imem_req=0, IF/ID held; on release IF/ID gets pc=16, next imem_addr=20, no instruction lost or duplicated.
- branch_taken=1, branch_target=32'h0000_0103 while ready=1 at pc=24 -> fetched word discarded; next imem_addr=32'h100; IF/ID bubble then pc=32'h100.
- flush=1 and stall=1 together -> IF/ID valid=0, instr=0 next cycle; pc unchanged.
- PC_RESET=32'hFFFF_FFFC, two fetches -> addresses FFFF_FFFC then 0000_0000, if_id_pc4=0; async rst pulse mid-BUF -> all outputs 0 immediately, imem_req=0.
